// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_pkg : shared types for the CPU/DMA memory arbiter             |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

  localparam int c_cnt_w    = 3;
  localparam int c_starve_w = 4;
  localparam int c_addr_w   = 16;
  localparam int c_data_w   = 8;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter : two-port (CPU/DMA) single-memory arbiter with starvation cap |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                ph1,
  input  logic                reset_b,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [c_addr_w-1:0] cpu_addr,
  input  logic [c_data_w-1:0] cpu_wdata,
  output logic [c_data_w-1:0] cpu_rdata,
  output logic                cpu_ready,
  input  logic                dma_req,
  input  logic                dma_we,
  input  logic [c_addr_w-1:0] dma_addr,
  input  logic [c_data_w-1:0] dma_wdata,
  output logic [c_data_w-1:0] dma_rdata,
  output logic                dma_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [c_addr_w-1:0] mem_addr,
  output logic [c_data_w-1:0] mem_wdata,
  input  logic [c_data_w-1:0] mem_rdata
);

  localparam logic [c_cnt_w-1:0]    c_lat    = c_cnt_w'(MEM_LAT);
  localparam logic [c_starve_w-1:0] c_starve = c_starve_w'(STARVE_MAX);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_starve_w-1:0] r_starve_cnt;
  port_e                 r_sel;
  port_e                 w_sel;
  logic                  w_grant;

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // CPU has priority unless the DMA port has waited through STARVE_MAX CPU grants.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_sel       = PORT_CPU;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ACCESS;
          if (dma_req && (!cpu_req || r_starve_cnt == c_starve)) w_sel = PORT_DMA;
        end
      end
      ST_ACCESS: if (r_cnt == '0) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      r_cnt        <= '0;
      r_starve_cnt <= '0;
      r_sel        <= PORT_CPU;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rdata    <= '0;
      dma_rdata    <= '0;
      cpu_ready    <= 1'b0;
      dma_ack      <= 1'b0;
    end else begin
      mem_en    <= w_grant;
      cpu_ready <= 1'b0;
      dma_ack   <= 1'b0;
      if (r_state == ST_IDLE && !dma_req) r_starve_cnt <= '0;
      if (w_grant) begin
        r_sel <= w_sel;
        r_cnt <= c_lat;
        if (w_sel == PORT_DMA) begin
          mem_we       <= dma_we;
          mem_addr     <= dma_addr;
          mem_wdata    <= dma_wdata;
          r_starve_cnt <= '0;
        end else begin
          mem_we    <= cpu_we;
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
          if (dma_req && r_starve_cnt != c_starve) r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end
      // Memory data is due on the edge where the latency count has run out.
      if (r_state == ST_ACCESS) begin
        if (r_cnt == '0) begin
          if (r_sel == PORT_DMA) begin
            dma_rdata <= mem_rdata;
            dma_ack   <= 1'b1;
          end else begin
            cpu_rdata <= mem_rdata;
            cpu_ready <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench for mem_arbiter (MEM_LAT=1 and 3)       |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int SMAX = 4;

  typedef struct {
    bit         dma;
    bit         we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } txn_t;

  logic        ph1 = 1'b0;
  logic        reset_b = 1'b0;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_ready, dma_ack, mem_en, mem_we;

  logic        cpu_req3 = 1'b0, cpu_we3 = 1'b0;
  logic [15:0] cpu_addr3 = '0, mem_addr3;
  logic [7:0]  cpu_wdata3 = '0, cpu_rdata3, dma_rdata3, mem_wdata3, mem_rdata3;
  logic        cpu_ready3, dma_ack3, mem_en3, mem_we3;

  always #5 ph1 = ~ph1;

  mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .ph1(ph1), .reset_b(reset_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(LAT3), .STARVE_MAX(SMAX)) dut3 (
    .ph1(ph1), .reset_b(reset_b),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
    .cpu_rdata(cpu_rdata3), .cpu_ready(cpu_ready3),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0000), .dma_wdata(8'h00),
    .dma_rdata(dma_rdata3), .dma_ack(dma_ack3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Background memory contents; 16'hFFFC reads as zero.
  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a == 16'hFFFC) return 8'h00;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory models: synchronous read registered on the mem_en edge, then LAT-1 extra stages.
  logic [7:0] wmem [logic [15:0]];
  logic [7:0] pipe1 [LAT];
  logic [7:0] pipe3 [LAT3];
  assign mem_rdata  = pipe1[LAT-1];
  assign mem_rdata3 = pipe3[LAT3-1];

  initial forever begin
    logic [7:0] rd;
    @(posedge ph1);
    rd = wmem.exists(mem_addr) ? wmem[mem_addr] : pat(mem_addr);
    if (mem_en && mem_we) wmem[mem_addr] = mem_wdata;
    pipe1[0] <= mem_en ? rd : 8'hA5;
    for (int i = 1; i < LAT; i++) pipe1[i] <= pipe1[i-1];
    pipe3[0] <= mem_en3 ? pat(mem_addr3) : 8'hA5;
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end

  // Reference memory and scoreboard.
  logic [7:0] ref_w [logic [15:0]];
  txn_t exp_q[$], cpu_q[$], dma_q[$];

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_w.exists(a) ? ref_w[a] : pat(a);
  endfunction

  function automatic txn_t mk(input bit dma, input bit we, input logic [15:0] a, input logic [7:0] d);
    txn_t t;
    t.dma = dma; t.we = we; t.addr = a; t.wdata = d; t.rdata = 8'h00;
    return t;
  endfunction

  task automatic issue(input txn_t t);
    if (t.dma) dma_q.push_back(t);
    else       cpu_q.push_back(t);
  endtask

  task automatic expect_txn(input txn_t t);
    if (t.we) ref_w[t.addr] = t.wdata;
    else      t.rdata = ref_rd(t.addr);
    exp_q.push_back(t);
  endtask

  int cyc = 0;
  int grant_cyc = 0;
  int n_ready = 0;
  bit prev_en = 1'b0;
  bit abort_mode = 1'b0;
  bit flush = 1'b0;

  initial forever begin
    @(posedge ph1);
    cyc++;
  end

  // Monitor and requester driver share one process so their order is fixed.
  initial begin : mon_drv
    txn_t e;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    forever begin
      @(negedge ph1);
      if (reset_b) begin
        if (mem_en) begin
          chk("mem_en_width", {31'd0, prev_en}, 0);
          grant_cyc = cyc;
          if (exp_q.size() == 0) begin
            if (!abort_mode) chk("spurious_grant", 1, 0);
          end else begin
            e = exp_q[0];
            chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
            if (e.we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
            // Disturb the granted requester's inputs; the access must not follow them.
            if (e.dma) begin dma_we = ~dma_we; dma_addr = ~dma_addr; dma_wdata = ~dma_wdata; end
            else       begin cpu_we = ~cpu_we; cpu_addr = ~cpu_addr; cpu_wdata = ~cpu_wdata; end
          end
        end
        if (cpu_ready || dma_ack) begin
          n_ready++;
          if (exp_q.size() == 0) begin
            chk("spurious_ready", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("ack_port", {31'd0, dma_ack}, {31'd0, e.dma});
            chk("single_ack", {31'd0, cpu_ready & dma_ack}, 0);
            chk("latency", cyc - grant_cyc, LAT + 1);
            chk("mem_addr_hold", {16'd0, mem_addr}, {16'd0, e.addr});
            chk("mem_we_hold", {31'd0, mem_we}, {31'd0, e.we});
            if (!e.we)
              chk(e.dma ? "dma_rdata" : "cpu_rdata",
                  {24'd0, (e.dma ? dma_rdata : cpu_rdata)}, {24'd0, e.rdata});
          end
          if (cpu_ready && cpu_q.size() > 0) begin void'(cpu_q.pop_front()); cpu_req = 1'b0; end
          if (dma_ack && dma_q.size() > 0) begin void'(dma_q.pop_front()); dma_req = 1'b0; end
        end
      end
      prev_en = mem_en;
      if (flush) begin
        cpu_q.delete(); dma_q.delete();
        cpu_req = 1'b0; dma_req = 1'b0;
      end
      if (!cpu_req && cpu_q.size() > 0) begin
        cpu_req = 1'b1; cpu_we = cpu_q[0].we; cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].wdata;
      end
      if (!dma_req && dma_q.size() > 0) begin
        dma_req = 1'b1; dma_we = dma_q[0].we; dma_addr = dma_q[0].addr; dma_wdata = dma_q[0].wdata;
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || cpu_req || dma_req) && n < budget) begin
      @(negedge ph1); #2;
      n++;
    end
    chk("drain_timeout", (n < budget) ? 1 : 0, 1);
    @(negedge ph1); #2;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_mem_en"},    {31'd0, mem_en}, 0);
    chk({pfx, "_mem_we"},    {31'd0, mem_we}, 0);
    chk({pfx, "_mem_addr"},  {16'd0, mem_addr}, 0);
    chk({pfx, "_mem_wdata"}, {24'd0, mem_wdata}, 0);
    chk({pfx, "_cpu_rdata"}, {24'd0, cpu_rdata}, 0);
    chk({pfx, "_dma_rdata"}, {24'd0, dma_rdata}, 0);
    chk({pfx, "_cpu_ready"}, {31'd0, cpu_ready}, 0);
    chk({pfx, "_dma_ack"},   {31'd0, dma_ack}, 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    txn_t t;
    int n;
    int rdy0;

    repeat (2) @(negedge ph1);
    #2;
    chk_reset_outputs("rst");

    // CPU read of 16'hFFFC queued during reset; granted on the first edge after release.
    t = mk(0, 0, 16'hFFFC, 8'h00); issue(t); expect_txn(t);
    @(negedge ph1); #2;
    reset_b = 1'b1;
    @(posedge ph1); #1;
    chk("first_grant", {31'd0, mem_en}, 1);
    wait_drain(50);

    // Simultaneous requests with no starvation history: CPU first, then DMA.
    t = mk(0, 0, 16'h0100, 8'h00); issue(t); expect_txn(t);
    t = mk(1, 0, 16'h0200, 8'h00); issue(t);
    expect_txn(t);
    wait_drain(50);

    // DMA write then CPU read-back.
    t = mk(1, 1, 16'h0040, 8'h42); issue(t); expect_txn(t);
    wait_drain(50);
    t = mk(0, 0, 16'h0040, 8'h00); issue(t); expect_txn(t);
    chk("readback_expect", {24'd0, exp_q[0].rdata}, 32'h42);
    wait_drain(50);

    // Starvation: four CPU grants, then DMA forced, then the last CPU request.
    for (int i = 0; i < 5; i++) issue(mk(0, 0, 16'h0010 + 16'(i), 8'h00));
    issue(mk(1, 0, 16'h0020, 8'h00));
    for (int i = 0; i < 4; i++) expect_txn(mk(0, 0, 16'h0010 + 16'(i), 8'h00));
    expect_txn(mk(1, 0, 16'h0020, 8'h00));
    expect_txn(mk(0, 0, 16'h0014, 8'h00));
    n = 0;
    while (!dma_ack && n < 100) begin @(negedge ph1); #2; n++; end
    chk("starve_dma_ack_seen", {31'd0, dma_ack}, 1);
    chk("starve_cnt_clear", {28'd0, dut.r_starve_cnt}, 0);
    chk("starve_dma_5th", exp_q.size(), 1);
    wait_drain(100);

    // Reset in the middle of an access: immediate reset values and no late ready.
    abort_mode = 1'b1;
    issue(mk(0, 0, 16'h0300, 8'h00));
    n = 0;
    while (!mem_en && n < 20) begin @(negedge ph1); #2; n++; end
    chk("abort_grant_seen", {31'd0, mem_en}, 1);
    reset_b = 1'b0;
    #1;
    chk_reset_outputs("abort");
    flush = 1'b1;
    @(negedge ph1); #2;
    flush = 1'b0;
    rdy0 = n_ready;
    reset_b = 1'b1;
    repeat (8) @(negedge ph1);
    #2;
    chk("no_ready_after_abort", n_ready, rdy0);
    abort_mode = 1'b0;

    // MEM_LAT=3 instance: ready after E4 for one cycle, next grant at E6.
    @(negedge ph1); #2;
    cpu_req3 = 1'b1; cpu_we3 = 1'b0; cpu_addr3 = 16'h0055;
    for (int k = 0; k <= 6; k++) begin
      @(posedge ph1); #1;
      chk($sformatf("lat3_mem_en_e%0d", k), {31'd0, mem_en3}, (k == 0 || k == 6) ? 1 : 0);
      chk($sformatf("lat3_ready_e%0d", k), {31'd0, cpu_ready3}, (k == 4) ? 1 : 0);
      if (k == 4) chk("lat3_rdata", {24'd0, cpu_rdata3}, {24'd0, pat(16'h0055)});
    end
    cpu_req3 = 1'b0;
    repeat (8) @(negedge ph1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: memory read latency in ph1 cycles, from the edge that samples mem_en to valid mem_rdata; legal range 1..4.
REQ-002 Parameter STARVE_MAX, default 4: consecutive CPU grants allowed while dma_req is pending before the DMA port is forced; legal range 1..15.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 ph1  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_b  in  1  asynchronous active-low reset.
REQ-006 cpu_req  in  1  core access request, held until cpu_ready.
REQ-007 cpu_we  in  1  core write enable, qualified by cpu_req.
REQ-008 cpu_addr  in  16  core address.
REQ-009 cpu_wdata  in  8  core write data.
REQ-010 cpu_rdata  out  8  read data, valid while cpu_ready=1.
REQ-011 cpu_ready  out  1  one-cycle completion pulse for the core.
REQ-012 dma_req, dma_we, dma_addr[16], dma_wdata[8]  in  loader/debug port request, same rules as the CPU port.
REQ-013 dma_rdata  out  8  read data, valid while dma_ack=1.
REQ-014 dma_ack  out  1  one-cycle completion pulse for the loader.
REQ-015 mem_en, mem_we  out  1  memory strobe and write enable.
REQ-016 mem_addr  out  16  memory address.
REQ-017 mem_wdata  out  8  memory write data.
REQ-018 mem_rdata  in  8  memory read data.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE.
REQ-020 IDLE: with any request at edge E0, latch the winner's we/addr/wdata into mem_*, set mem_en=1 and go to ACCESS with cnt=MEM_LAT; with no request, stay in IDLE with mem_en=0.
REQ-021 Arbitration in IDLE: CPU wins over DMA, except DMA wins when dma_req=1 and starve_cnt==STARVE_MAX.
REQ-022 starve_cnt: increments (saturating at STARVE_MAX) on each CPU grant made while dma_req=1; clears on each DMA grant; clears when dma_req=0 in IDLE.
REQ-023 mem_en is high for exactly one cycle (E0 to E1); from E1, mem_en=0 and mem_addr/mem_we/mem_wdata hold their values until the next grant.
REQ-024 ACCESS: cnt decrements every edge; at edge E(1+MEM_LAT), capture mem_rdata into the granted port's rdata register, pulse that port's ready/ack, and go to DONE.
REQ-025 DONE: lasts one cycle; ready/ack high only in this cycle; at E(2+MEM_LAT), return to IDLE.
REQ-026 The earliest next grant is at E(3+MEM_LAT); requests are not sampled in ACCESS or DONE.
REQ-027 Writes follow the same timing; rdata is still loaded from mem_rdata and is don't-care to requesters.
REQ-028 Only the granted port's rdata register changes; the other port's rdata holds its last value.
REQ-029 A request withdrawn before grant is ignored without error.
REQ-030 Requester inputs changing between grant and ready/ack do not affect mem_* outputs.

Reset
REQ-031 reset_b=0 immediately forces: state IDLE, starve_cnt=0, cnt=0, mem_en=0, mem_we=0, mem_addr=16'h0000, mem_wdata=8'h00, cpu_rdata=8'h00, dma_rdata=8'h00, cpu_ready=0, dma_ack=0.
REQ-032 Reset asserted during ACCESS or DONE aborts the access; no ready/ack is issued for it.
REQ-033 The first grant is possible at the first rising edge after reset_b deasserts.

Structure
REQ-034 The state enum (IDLE, ACCESS, DONE) and the port-select encoding (CPU=0, DMA=1) belong in the shared core package.
REQ-035 Single module; no sub-modules.
REQ-036 A one-bit register records the granted port for the duration of the access.

Verification
REQ-037 Reset: reset_b=0 mid-ACCESS -> all outputs at reset values within the same cycle; no ready/ack after release.
REQ-038 CPU read, MEM_LAT=1: cpu_addr=16'hFFFC, mem_rdata=8'h00 -> mem_en for one cycle; cpu_ready in the cycle after edge E2 with cpu_rdata=8'h00; mem_en low again.
REQ-039 Simultaneous: cpu_req and dma_req both set, starve_cnt=0 -> CPU granted first; DMA granted at the next IDLE sample once cpu_req drops.
REQ-040 Starvation, STARVE_MAX=4: cpu_req held high continuously with dma_req=1 -> CPU grants 1-4, then DMA grant 5, then starve_cnt=0.
REQ-041 DMA write: dma_we=1, dma_addr=16'h0040, dma_wdata=8'h42 -> mem_we=1, mem_addr=16'h0040, mem_wdata=8'h42 for one mem_en cycle; a following CPU read of 16'h0040 returns 8'h42.
REQ-042 MEM_LAT=3: CPU read -> cpu_ready in the cycle after edge E4, high exactly one cycle; next grant no earlier than E6.
